lpf_nibble_tx: RTL

//  Source/sink companion for the 16-tap nibble-serial LPF. Buffers 8-bit samples from upstream,

---
 rtl/lpf_pkg.sv | 22 ++
 rtl/lpf_tx_fifo.sv | 59 +++++
 rtl/lpf_nibble_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lpf_pkg.sv
// Shared state encoding, frame constants and helpers for the nibble-serial LPF companion.
package lpf_pkg;

  localparam int LPF_CAL_CYCLES = 16;
  localparam int FRAME_LEN      = LPF_CAL_CYCLES + 4;
  localparam int NIB_W          = 4;
  localparam int SMP_W          = 8;

  typedef enum logic [2:0] {
    ST_RST,
    ST_WAIT,
    ST_LO,
    ST_HI,
    ST_CAL,
    ST_OUT
  } lpf_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lpf_tx_fifo.sv
// Synchronous sample FIFO, power-of-two depth; storage is not reset, only pointers and count.
module lpf_tx_fifo
  import lpf_pkg::*;
#(
  parameter int DATA_W = SMP_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lpf_nibble_tx.sv
// Feeds buffered samples to the LPF as lo/hi nibbles on its fixed frame and captures y.
// Optional LPF_TX_STATS_EN adds frame_cnt / underrun_cnt outputs.
module lpf_nibble_tx
  import lpf_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CAL_CYCLES = LPF_CAL_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [3:0] x_half,
  input  logic [7:0] y,
  output logic [7:0] m_y,
  output logic       m_y_valid,
  output logic       m_y_fill,
  output logic       underrun
`ifdef LPF_TX_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  underrun_cnt
`endif
);

  localparam int CNT_W = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CAL_CYCLES - 1);

  lpf_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SMP_W-1:0] hold_q;
  logic             fill_q;
  logic [NIB_W-1:0] x_half_q;
  logic [SMP_W-1:0] m_y_q;
  logic             m_y_valid_q;
  logic             m_y_fill_q;
  logic             underrun_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic [SMP_W-1:0] fifo_head;
  logic             push;
  logic             pop;

  // Ready is forced low while reset is held so nothing is accepted into a clearing buffer.
  assign s_ready = !fifo_full && !reset;
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == ST_WAIT) && !fifo_empty;

  lpf_tx_fifo #(
    .DATA_W(SMP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .wdata_i(s_data),
    .pop_i  (pop),
    .rdata_o(fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // One state per LPF cycle; the schedule never stalls so alignment depends only on reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      hold_q      <= '0;
      fill_q      <= 1'b0;
      x_half_q    <= '0;
      m_y_q       <= '0;
      m_y_valid_q <= 1'b0;
      m_y_fill_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      x_half_q    <= '0;
      m_y_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      case (state_q)
        ST_RST: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          state_q <= ST_LO;
          if (!fifo_empty) begin
            hold_q   <= fifo_head;
            x_half_q <= fifo_head[NIB_W-1:0];
            fill_q   <= 1'b0;
          end else begin
            hold_q     <= '0;
            fill_q     <= 1'b1;
            underrun_q <= 1'b1;
          end
        end
        ST_LO: begin
          state_q  <= ST_HI;
          x_half_q <= hold_q[SMP_W-1:NIB_W];
        end
        ST_HI: begin
          state_q <= ST_CAL;
          cnt_q   <= '0;
        end
        ST_CAL: begin
          if (cnt_q == CNT_LAST) state_q <= ST_OUT;
          else                   cnt_q   <= cnt_q + CNT_W'(1);
        end
        ST_OUT: begin
          state_q     <= ST_WAIT;
          m_y_q       <= y;
          m_y_valid_q <= 1'b1;
          m_y_fill_q  <= fill_q;
        end
        default: begin
          state_q <= ST_RST;
        end
      endcase
    end
  end

  assign x_half    = x_half_q;
  assign m_y       = m_y_q;
  assign m_y_valid = m_y_valid_q;
  assign m_y_fill  = m_y_fill_q;
  assign underrun  = underrun_q;

`ifdef LPF_TX_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  underrun_cnt_q;

  // Counters advance on the same edges that raise m_y_valid and underrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      if (state_q == ST_OUT) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((state_q == ST_WAIT) && fifo_empty) underrun_cnt_q <= sat_inc8(underrun_cnt_q);
    end
  end

  assign frame_cnt    = frame_cnt_q;
  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule
